i2c_frame_ctrl: RTL and testbench
=================================

# i2c_frame_ctrl

I2C target-side transaction sequencer placed directly behind `i2c_detector`. It consumes the detector's start, stop and SCL-edge pulses together with synchronised SDA, frames bits into address and data bytes, and matches the 7-bit device address. It drives the open-drain SDA enable for ACK and read-data bits. It hands received bytes to the register side and requests transmit bytes from it.

## Interface
- `DEV_ADDR`, 7'h2A: 7-bit target address.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sda_in` in 1: synchronised SDA level; the same signal that feeds `i2c_detector`.
- `start_in` in 1: one-cycle START pulse (`start_out` of detector).
- `stop_in` in 1: one-cycle STOP pulse.
- `scl_rise_in` in 1: one-cycle SCL rising-edge pulse.
- `scl_fall_in` in 1: one-cycle SCL falling-edge pulse.
- `tx_data` in 8: byte to return on a read; sampled only on a `tx_load` cycle.
- `sda_oe` out 1: 1 pulls SDA low (ACK or data 0); 0 releases the line.
- `rx_data` out 8: last received write byte; holds its value until the next byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_load` out 1: one-cycle pulse; `tx_data` is captured in this cycle.
- `addr_hit` out 1: high while this target is addressed (from address ACK until STOP or START).
- `rw` out 1: R/W bit of the current transaction (1 = read); valid while `addr_hit` = 1.
- `busy` out 1: high from START until STOP.

## Operation
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Event priority within one cycle: `start_in` > `stop_in` > SCL edges.
- `start_in` in any state:
  - go to ADDR;
  - clear the bit counter and shift register;
  - `sda_oe` = 0, `addr_hit` = 0, `busy` = 1.
  - This covers repeated START.
- `stop_in` in any state: go to IDLE; `sda_oe` = 0, `addr_hit` = 0, `busy` = 0.
- SDA sampling and driving:
  - Bits are sampled from `sda_in` on `scl_rise_in`, MSB first, into an 8-bit shift register with a 0..7 counter.
  - `sda_oe` changes only on `scl_fall_in`.
- ADDR:
  - On the 8th rise, compare bits[7:1] with `DEV_ADDR`.
  - Match: latch `rw` = bit0 and arm ACK.
  - Mismatch: go to IGNORE.
- ADDR_ACK:
  - On the next fall, set `sda_oe` = 1 and `addr_hit` = 1.
  - On the following (9th) rise, no action.
  - On the next fall:
    - `rw` = 0: set `sda_oe` = 0 and go to WR_DATA.
    - `rw` = 1: pulse `tx_load`, load `tx_data` into the transmit shift register, set `sda_oe` = ~`tx_data`[7], and go to RD_DATA.
- WR_DATA: on the 8th rise, update `rx_data` and pulse `rx_valid`, then go to WR_ACK. All write bytes are ACKed.
- WR_ACK:
  - Fall: set `sda_oe` = 1.
  - 9th rise: no action.
  - Next fall: set `sda_oe` = 0 and go to WR_DATA.
- RD_DATA:
  - Each fall after the first bit: shift, then `sda_oe` = ~next bit.
  - The fall after the 8th rise sets `sda_oe` = 0 (release for the master's ACK); go to RD_ACK.
- RD_ACK: on the 9th rise, sample `sda_in`.
  - 0 (ACK): on the next fall, pulse `tx_load`, drive the MSB of the new byte, and go to RD_DATA.
  - 1 (NACK): go to IGNORE with `sda_oe` = 0.
- IGNORE: `sda_oe` = 0; only START or STOP exits.
- SCL edges in IDLE are ignored.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `sda_oe`, `rx_valid`, `tx_load`, `addr_hit`, `rw`, `busy` = 0;
  - `rx_data` = 8'h00.
- All outputs are registered.
- `sda_oe` changes the cycle after the `scl_fall_in` pulse.
- `rx_valid` asserts the cycle after the 8th `scl_rise_in` pulse.
- `tx_load` asserts the cycle after the relevant `scl_fall_in` pulse.
- `busy` and `addr_hit` update the cycle after `start_in` or `stop_in`.
- Reset mid-transaction: all outputs return to reset values immediately, so SDA is released asynchronously; the block waits for a new START.
- A STOP or START mid-byte discards the partial byte; no `rx_valid` is issued.

## Test plan
- `DEV_ADDR` = 2A. Stimulus: START, 8'h54, then 8'hA5, then STOP.
  - `sda_oe` = 1 during both 9th clocks.
  - `rx_valid` pulses once with `rx_data` = A5.
  - `addr_hit` = 1 then 0 after STOP.
- Stimulus: START, 8'h56 (address 2B).
  - No ACK: `sda_oe` stays 0.
  - `addr_hit` = 0; following bytes are ignored until STOP.
- Stimulus: START, 8'h55, `tx_data` = 3C, master ACK, then NACK on the second byte (`tx_data` = C3).
  - `sda_oe` per bit = 1,1,0,0,0,0,1,1, then 0,0,1,1,1,1,0,0.
  - `tx_load` pulses twice.
  - After the NACK: IGNORE, `sda_oe` = 0.
- Stimulus: write 8'h54, 8'h11, then repeated START, 8'h55.
  - `rx_data` = 11.
  - `rw` = 1 after the second ACK.
  - `busy` stays 1 throughout.
- Stimulus: STOP after 4 bits of a write data byte.
  - No `rx_valid`; state IDLE; `busy` = 0.
- Stimulus: assert `rst_n` = 0 while `sda_oe` = 1 during ACK.
  - `sda_oe` drops without waiting for a clock edge.
  - After release, SCL edges are ignored until START.

Source files
------------

// File: rtl/i2c_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_frame_ctrl
// Description : I2C target transaction sequencer behind i2c_detector; frames
//               address/data bytes, matches DEV_ADDR, drives ACK/read data.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_frame_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_in,
    input  logic       start_in,
    input  logic       stop_in,
    input  logic       scl_rise_in,
    input  logic       scl_fall_in,
    input  logic [7:0] tx_data,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ADDR     = 3'd1;
    localparam logic [2:0] c_ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] c_ST_WR_DATA  = 3'd3;
    localparam logic [2:0] c_ST_WR_ACK   = 3'd4;
    localparam logic [2:0] c_ST_RD_DATA  = 3'd5;
    localparam logic [2:0] c_ST_RD_ACK   = 3'd6;
    localparam logic [2:0] c_ST_IGNORE   = 3'd7;

    // Sub-step within a bit slot: which SCL edge the current state expects next.
    localparam logic [1:0] c_PH_WAIT = 2'd0;
    localparam logic [1:0] c_PH_ONE  = 2'd1;
    localparam logic [1:0] c_PH_TWO  = 2'd2;

    logic [2:0] r_state;
    logic [1:0] r_phase;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [6:0] r_tx_shift;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_load;
    logic       r_addr_hit;
    logic       r_rw;
    logic       r_busy;

    logic [7:0] w_byte;
    logic       w_last_bit;

    // The 8th bit is merged straight from sda_in, so only 7 bits need storing.
    assign w_byte     = {r_shift, sda_in};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_phase    <= c_PH_WAIT;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_tx_shift <= 7'd0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_addr_hit <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            if (start_in) begin
                r_state    <= c_ST_ADDR;
                r_phase    <= c_PH_WAIT;
                r_bit_cnt  <= 3'd0;
                r_shift    <= 7'd0;
                r_sda_oe   <= 1'b0;
                r_addr_hit <= 1'b0;
                r_busy     <= 1'b1;
            end else if (stop_in) begin
                r_state    <= c_ST_IDLE;
                r_phase    <= c_PH_WAIT;
                r_bit_cnt  <= 3'd0;
                r_shift    <= 7'd0;
                r_sda_oe   <= 1'b0;
                r_addr_hit <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_ADDR: begin
                        if (scl_rise_in) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_phase <= c_PH_WAIT;
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= c_ST_ADDR_ACK;
                                end else begin
                                    r_state <= c_ST_IGNORE;
                                end
                            end
                        end
                    end
                    c_ST_ADDR_ACK: begin
                        if (scl_fall_in && r_phase == c_PH_WAIT) begin
                            r_sda_oe   <= 1'b1;
                            r_addr_hit <= 1'b1;
                            r_phase    <= c_PH_ONE;
                        end else if (scl_rise_in && r_phase == c_PH_ONE) begin
                            r_phase <= c_PH_TWO;
                        end else if (scl_fall_in && r_phase == c_PH_TWO) begin
                            r_phase   <= c_PH_WAIT;
                            r_bit_cnt <= 3'd0;
                            if (r_rw) begin
                                r_tx_load  <= 1'b1;
                                r_tx_shift <= tx_data[6:0];
                                r_sda_oe   <= ~tx_data[7];
                                r_state    <= c_ST_RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= c_ST_WR_DATA;
                            end
                        end
                    end
                    c_ST_WR_DATA: begin
                        if (scl_rise_in) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                                r_phase    <= c_PH_WAIT;
                                r_state    <= c_ST_WR_ACK;
                            end
                        end
                    end
                    c_ST_WR_ACK: begin
                        if (scl_fall_in && r_phase == c_PH_WAIT) begin
                            r_sda_oe <= 1'b1;
                            r_phase  <= c_PH_ONE;
                        end else if (scl_rise_in && r_phase == c_PH_ONE) begin
                            r_phase <= c_PH_TWO;
                        end else if (scl_fall_in && r_phase == c_PH_TWO) begin
                            r_sda_oe  <= 1'b0;
                            r_phase   <= c_PH_WAIT;
                            r_bit_cnt <= 3'd0;
                            r_state   <= c_ST_WR_DATA;
                        end
                    end
                    c_ST_RD_DATA: begin
                        // PH_TWO marks that the 8th bit has been clocked out.
                        if (scl_rise_in) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_phase   <= w_last_bit ? c_PH_TWO : c_PH_ONE;
                        end else if (scl_fall_in && r_phase == c_PH_ONE) begin
                            r_sda_oe   <= ~r_tx_shift[6];
                            r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            r_phase    <= c_PH_WAIT;
                        end else if (scl_fall_in && r_phase == c_PH_TWO) begin
                            r_sda_oe <= 1'b0;
                            r_phase  <= c_PH_WAIT;
                            r_state  <= c_ST_RD_ACK;
                        end
                    end
                    c_ST_RD_ACK: begin
                        if (scl_rise_in && r_phase == c_PH_WAIT) begin
                            if (!sda_in) begin
                                r_phase <= c_PH_ONE;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= c_ST_IGNORE;
                            end
                        end else if (scl_fall_in && r_phase == c_PH_ONE) begin
                            r_tx_load  <= 1'b1;
                            r_tx_shift <= tx_data[6:0];
                            r_sda_oe   <= ~tx_data[7];
                            r_phase    <= c_PH_WAIT;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= c_ST_RD_DATA;
                        end
                    end
                    c_ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign addr_hit = r_addr_hit;
    assign rw       = r_rw;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_frame_ctrl
// Description : Self-checking bench for i2c_frame_ctrl (vector table plus
//               hand-written read, repeated-START, abort and reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sda_in = 1'b1;
    logic       start_in = 1'b0;
    logic       stop_in = 1'b0;
    logic       scl_rise_in = 1'b0;
    logic       scl_fall_in = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       addr_hit;
    logic       rw;
    logic       busy;

    i2c_frame_ctrl #(.DEV_ADDR(7'h2A)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sda_in     (sda_in),
        .start_in   (start_in),
        .stop_in    (stop_in),
        .scl_rise_in(scl_rise_in),
        .scl_fall_in(scl_fall_in),
        .tx_data    (tx_data),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_load    (tx_load),
        .addr_hit   (addr_hit),
        .rw         (rw),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         rx_extra = 0;
    int         tx_cnt = 0;
    int         busy_drop = 0;
    logic       busy_watch = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] last_rx = 8'h00;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        logic       exp_ack;
    } wr_vec_t;

    wr_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every rx_valid pops the byte queued when it was sent.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_q.size() > 0) check("rx_data_sb", rx_data, rx_q.pop_front());
            else rx_extra++;
        end
        if (tx_load) tx_cnt++;
        if (busy_watch && !busy) busy_drop++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic oe_seen);
        cyc(2);
        oe_seen = sda_oe;
        sda_in = b & ~sda_oe;
        cyc(1);
        scl_rise_in = 1'b1; cyc(1); scl_rise_in = 1'b0;
        cyc(2);
        scl_fall_in = 1'b1; cyc(1); scl_fall_in = 1'b0;
    endtask

    task automatic do_start();
        cyc(1);
        sda_in = 1'b0;
        start_in = 1'b1; cyc(1); start_in = 1'b0;
        cyc(1);
        scl_fall_in = 1'b1; cyc(1); scl_fall_in = 1'b0;
    endtask

    task automatic do_stop();
        cyc(2);
        stop_in = 1'b1; cyc(1); stop_in = 1'b0;
        sda_in = 1'b1;
        cyc(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_oe);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack_oe);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                             output logic [7:0] oe_bits, output logic ack_oe);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, o);
            oe_bits[i] = o;
        end
        tx_data = next_tx;
        clock_bit(~master_ack, ack_oe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       d;
        logic [7:0] oe_bits;
        int         tx0;

        vecs[0] = '{8'h54, 8'hA5, 1'b1};
        vecs[1] = '{8'h56, 8'h33, 1'b0};
        vecs[2] = '{8'h54, 8'h00, 1'b1};
        vecs[3] = '{8'hA8, 8'h5A, 1'b0};
        vecs[4] = '{8'h54, 8'hFF, 1'b1};
        vecs[5] = '{8'h14, 8'hC3, 1'b0};

        cyc(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_load", tx_load, 0);
        check("rst_addr_hit", addr_hit, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 6; i++) begin
            do_start();
            check("busy_after_start", busy, 1);
            write_byte(vecs[i].addr_byte, ack);
            check("addr_ack", ack, vecs[i].exp_ack);
            check("addr_hit", addr_hit, vecs[i].exp_ack);
            if (vecs[i].exp_ack) begin
                rx_q.push_back(vecs[i].data_byte);
                last_rx = vecs[i].data_byte;
            end
            write_byte(vecs[i].data_byte, ack);
            check("data_ack", ack, vecs[i].exp_ack);
            check("rx_drained", rx_q.size(), 0);
            check("rx_hold", rx_data, last_rx);
            do_stop();
            check("hit_after_stop", addr_hit, 0);
            check("busy_after_stop", busy, 0);
            check("oe_after_stop", sda_oe, 0);
        end
        check("rx_extra_tbl", rx_extra, 0);

        // Read: 3C with master ACK, then C3 with master NACK.
        tx0 = tx_cnt;
        tx_data = 8'h3C;
        do_start();
        write_byte(8'h55, ack);
        check("rd_addr_ack", ack, 1);
        check("rd_rw", rw, 1);
        read_byte(1'b1, 8'hC3, oe_bits, ack);
        check("rd_bits0", oe_bits, 8'hC3);
        check("rd_release0", ack, 0);
        read_byte(1'b0, 8'hC3, oe_bits, ack);
        check("rd_bits1", oe_bits, 8'h3C);
        check("rd_release1", ack, 0);
        check("tx_load_count", tx_cnt - tx0, 2);
        check("oe_after_nack", sda_oe, 0);
        write_byte(8'h00, ack);
        check("ignore_no_ack", ack, 0);
        check("ignore_no_tx", tx_cnt - tx0, 2);
        do_stop();

        // Repeated START: write 11, then re-address for read.
        do_start();
        busy_watch = 1'b1;
        write_byte(8'h54, ack);
        rx_q.push_back(8'h11);
        last_rx = 8'h11;
        write_byte(8'h11, ack);
        check("rs_data_ack", ack, 1);
        do_start();
        write_byte(8'h55, ack);
        check("rs_addr_ack", ack, 1);
        check("rs_rw", rw, 1);
        check("rs_rx_data", rx_data, 8'h11);
        check("rs_rx_drained", rx_q.size(), 0);
        busy_watch = 1'b0;
        check("rs_busy_held", busy_drop, 0);
        do_stop();

        // STOP after 4 bits of a write byte.
        do_start();
        write_byte(8'h54, ack);
        check("ab_addr_ack", ack, 1);
        clock_bit(1'b1, d); clock_bit(1'b0, d); clock_bit(1'b1, d); clock_bit(1'b1, d);
        do_stop();
        check("ab_busy", busy, 0);
        check("ab_hit", addr_hit, 0);
        check("ab_rx_extra", rx_extra, 0);
        check("ab_rx_data", rx_data, last_rx);
        write_byte(8'h54, ack);
        check("ab_idle_no_ack", ack, 0);

        // Asynchronous reset while ACK is driven.
        do_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'h54 >> i) & 8'h01) != 0, d);
        check("pre_rst_oe", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_oe", sda_oe, 0);
        check("async_rst_hit", addr_hit, 0);
        check("async_rst_busy", busy, 0);
        cyc(2);
        rst_n = 1'b1;
        sda_in = 1'b1;
        cyc(2);
        write_byte(8'h54, ack);
        check("post_rst_no_ack", ack, 0);
        check("post_rst_hit", addr_hit, 0);
        do_start();
        write_byte(8'h54, ack);
        check("post_rst_start_ack", ack, 1);
        do_stop();

        check("final_rx_extra", rx_extra, 0);
        check("final_rx_queue", rx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
